// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Drives a row of WIDTH LEDs with one of four animated patterns. A prescaler
//   divides the enabled clock by DIV, and each prescaler wrap advances the
//   pattern by one step.
//
// Ports
//   clk         in   rising-edge clock for all state
//   reset       in   asynchronous active-low reset (release synchronised externally)
//   en          in   run enable; low freezes prescaler, pattern and direction
//   mode[1:0]   in   requested pattern: 0 BLINK, 1 SHIFT, 2 FILL, 3 PINGPONG
//   OUT[W-1:0]  out  registered LED pattern
//   mode_q[1:0] out  registered active pattern
//   cycle_done  out  registered one-cycle pulse when a pattern period wraps
module led_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] OUT,
   output logic [1:0]       mode_q,
   output logic             cycle_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] PAT_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] PAT_BIT0 = WIDTH'(1);

   localparam logic [1:0] MODE_BLINK    = 2'd0;
   localparam logic [1:0] MODE_SHIFT    = 2'd1;
   localparam logic [1:0] MODE_FILL     = 2'd2;
   localparam logic [1:0] MODE_PINGPONG = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic [WIDTH-1:0] out_q, out_d;
   logic [1:0]       mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             step_s;

   // Pattern each mode shows immediately after it is selected.
   function automatic logic [WIDTH-1:0] start_value(input logic [1:0] m);
      case (m)
         MODE_BLINK:    return PAT_ZERO;
         MODE_SHIFT:    return PAT_BIT0;
         MODE_FILL:     return PAT_ZERO;
         MODE_PINGPONG: return PAT_BIT0;
         default:       return PAT_ZERO;
      endcase
   endfunction

   // Exactly one bit set.
   function automatic logic is_onehot(input logic [WIDTH-1:0] v);
      return (v != PAT_ZERO) && ((v & (v - PAT_BIT0)) == PAT_ZERO);
   endfunction

   // Contiguous run of ones starting at bit 0 (all-zeros included).
   function automatic logic is_fill(input logic [WIDTH-1:0] v);
      return (v & (v + PAT_BIT0)) == PAT_ZERO;
   endfunction

   assign step_s = en & (cnt_q == CNT_MAX);

   // Next-state logic: a mode change overrides everything, including a
   // coincident step; otherwise the prescaler runs only while enabled.
   always_comb begin
      out_d  = out_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      done_d = 1'b0;
      if (mode != mode_q) begin
         mode_d = mode;
         cnt_d  = CNT_ZERO;
         dir_d  = DIR_UP;
         out_d  = start_value(mode);
      end else if (en) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
         if (step_s) begin
            case (mode_q)
               MODE_BLINK: begin
                  if (out_q == PAT_ZERO) begin
                     out_d = PAT_ONES;
                  end else if (out_q == PAT_ONES) begin
                     out_d  = PAT_ZERO;
                     done_d = 1'b1;
                  end else begin
                     out_d = PAT_ZERO;
                  end
               end
               MODE_SHIFT: begin
                  if (is_onehot(out_q)) begin
                     out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                     done_d = out_q[WIDTH-1];
                  end else begin
                     out_d = PAT_BIT0;
                  end
               end
               MODE_FILL: begin
                  if (!is_fill(out_q)) begin
                     out_d = PAT_ZERO;
                  end else if (out_q == PAT_ONES) begin
                     out_d  = PAT_ZERO;
                     done_d = 1'b1;
                  end else begin
                     out_d = {out_q[WIDTH-2:0], 1'b1};
                  end
               end
               MODE_PINGPONG: begin
                  if (!is_onehot(out_q)) begin
                     out_d = PAT_BIT0;
                     dir_d = DIR_UP;
                  end else if (((dir_q == DIR_UP) && !out_q[WIDTH-1]) || out_q[0]) begin
                     // Moving up; turn around once the top bit is reached.
                     out_d = {out_q[WIDTH-2:0], 1'b0};
                     dir_d = out_q[WIDTH-2] ? DIR_DOWN : DIR_UP;
                  end else begin
                     // Moving down; arriving at bit 0 closes the period.
                     out_d  = {1'b0, out_q[WIDTH-1:1]};
                     dir_d  = out_q[1] ? DIR_UP : DIR_DOWN;
                     done_d = out_q[1];
                  end
               end
               default: begin
                  out_d = PAT_ZERO;
               end
            endcase
         end else begin
            out_d = out_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with asynchronous active-low reset to idle BLINK.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= PAT_ZERO;
         mode_q <= MODE_BLINK;
         cnt_q  <= CNT_ZERO;
         dir_q  <= DIR_UP;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         done_q <= done_d;
      end
   end

   assign OUT        = out_q;
   assign cycle_done = done_q;

endmodule
